regfile_writeback: RTL and testbench

//  Writer side of the register_file write port. Accepts execute-stage results over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.

---
 rtl/regfile_writeback_pkg.sv | 37 +++
 rtl/regfile_writeback_wb_fifo.sv | 97 +++++++++
 rtl/regfile_writeback.sv | 178 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// regfile_writeback_pkg
//   Shared opcode definitions for the register-file writeback path.
//   - alu_control codes that have special writeback behaviour
//   - fixed destination registers of the dual-result ops (HI/LO)
//   - op classifier used by the writeback top and its hazard compare
// -----------------------------------------------------------------------------
package regfile_writeback_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NONE = 4'd0;  // no result, accepted and dropped
  localparam logic [OP_W-1:0] OP_MUL  = 4'd1;  // dual result: HI/LO
  localparam logic [OP_W-1:0] OP_DIV  = 4'd2;  // dual result: HI/LO
  localparam logic [OP_W-1:0] OP_ALU  = 4'd3;  // first of the single-result codes

  localparam int HI_REG = 19;
  localparam int LO_REG = 20;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_DUAL   = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    op_class_e cls;
    cls = CLS_SINGLE;
    if (op == OP_NONE) begin
      cls = CLS_NONE;
    end else if ((op == OP_MUL) || (op == OP_DIV)) begin
      cls = CLS_DUAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   DEPTH-entry FIFO of packed writeback entries with synchronous flush.
//   Every slot is exposed together with a valid bit so the parent can compare
//   all pending destinations in parallel; for that reason storage is a plain
//   register array rather than a RAM with a single read port.
// Ports
//   clk, rst_n   clock, async active-low reset (pointers/count only)
//   flush        discard all entries at the edge (wins over push/pop)
//   push         write push_data at tail (ignored when full)
//   pop          advance head (ignored when empty)
//   head_data    entry at the head
//   count        occupancy, 0..DEPTH
//   slot_valid   per physical slot: holds a live entry
//   slot_data    per physical slot: stored entry
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            push,
  input  logic [W-1:0]                    push_data,
  input  logic                            pop,
  output logic [W-1:0]                    head_data,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                slot_valid,
  output logic [DEPTH-1:0][W-1:0]         slot_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // Pointers are PW bits wide, so wrap modulo DEPTH is free (DEPTH is 2^PW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage needs no reset: slot_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  // A physical slot is live when its distance from the head (mod DEPTH)
  // is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] slot_off;
      assign slot_off       = PW'(gi) - rd_ptr_reg;
      assign slot_valid[gi] = ({1'b0, slot_off} < count_reg);
      assign slot_data[gi]  = mem[gi];
    end
  endgenerate

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Writer side of the register_file write port. Execute-stage results arrive
//   over valid/ready, are buffered in a DEPTH-entry FIFO and drained one per
//   cycle into a registered rf_* port. Decode can query whether a source
//   register still has a write in flight (FIFO or live rf_* register).
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   result handshake (in_ready low during reset/flush/full)
//   in_op               alu_control code (0 = no result, 1/2 = dual HI/LO)
//   in_waddr            destination for single-result ops
//   in_wdata0/1         primary / secondary result
//   wb_hold             freeze draining
//   flush               discard all queued writes at the edge
//   chk_addr0/1         decode source registers
//   chk_busy0/1         source has a pending write
//   fifo_count          FIFO occupancy
//   rf_wren, rf_waddr, rf_wdata0/1, rf_alu_control   register_file write port
// Configuration
//   WB_BYPASS_EN  when defined, a result arriving with the FIFO empty and no
//                 hold goes straight into the rf_* register at its push edge.
// -----------------------------------------------------------------------------
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [AW-1:0]            in_waddr,
  input  logic [DW-1:0]            in_wdata0,
  input  logic [DW-1:0]            in_wdata1,
  input  logic                     wb_hold,
  input  logic                     flush,
  input  logic [AW-1:0]            chk_addr0,
  input  logic [AW-1:0]            chk_addr1,
  output logic                     chk_busy0,
  output logic                     chk_busy1,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     rf_wren,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata0,
  output logic [DW-1:0]            rf_wdata1,
  output logic [3:0]               rf_alu_control
);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata0;
    logic [DW-1:0]   wdata1;
  } wb_entry_t;

  localparam int EW = $bits(wb_entry_t);

  // Destination test for one entry: dual ops always target HI and LO.
  function automatic logic dest_match(input wb_entry_t e, input logic [AW-1:0] a);
    logic hit;
    if (classify(e.op) == CLS_DUAL) begin
      hit = (a == AW'(HI_REG)) || (a == AW'(LO_REG));
    end else begin
      hit = (a == e.waddr);
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------------
  // Input classification
  // ---------------------------------------------------------------------------
  op_class_e in_class;
  wb_entry_t in_entry;
  logic      accept;
  logic      push_req;
  logic      bypass_load;
  logic      fifo_push;
  logic      fifo_pop;

  wb_entry_t                     head_entry;
  logic [EW-1:0]                 head_bits;
  logic [DEPTH-1:0]              slot_valid;
  logic [DEPTH-1:0][EW-1:0]      slot_bits;

  assign in_class = classify(in_op);

  // Dual ops carry a canonical HI destination; waddr from execute is ignored.
  assign in_entry.op     = in_op;
  assign in_entry.waddr  = (in_class == CLS_DUAL) ? AW'(HI_REG) : in_waddr;
  assign in_entry.wdata0 = in_wdata0;
  assign in_entry.wdata1 = in_wdata1;

  // Ready depends only on registered occupancy and external controls, never
  // on this cycle's drain decision.
  assign in_ready = rst_n & ~flush & (fifo_count != ($clog2(DEPTH)+1)'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push_req = accept & (in_class != CLS_NONE);

`ifdef WB_BYPASS_EN
  assign bypass_load = push_req & (fifo_count == '0) & ~wb_hold;
`else
  assign bypass_load = 1'b0;
`endif

  assign fifo_push = push_req & ~bypass_load;
  assign fifo_pop  = (fifo_count != '0) & ~wb_hold & ~flush;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (fifo_push),
    .push_data  (in_entry),
    .pop        (fifo_pop),
    .head_data  (head_bits),
    .count      (fifo_count),
    .slot_valid (slot_valid),
    .slot_data  (slot_bits)
  );

  assign head_entry = wb_entry_t'(head_bits);

  // ---------------------------------------------------------------------------
  // rf_* output register: payload holds when nothing is written this cycle.
  // ---------------------------------------------------------------------------
  wb_entry_t rf_entry_reg;
  logic      rf_wren_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_entry_reg <= '0;
      rf_wren_reg  <= 1'b0;
    end else if (flush) begin
      // The write already presented this cycle commits at this edge; nothing
      // new is launched.
      rf_wren_reg <= 1'b0;
    end else if (fifo_pop) begin
      rf_entry_reg <= head_entry;
      rf_wren_reg  <= 1'b1;
    end else if (bypass_load) begin
      rf_entry_reg <= in_entry;
      rf_wren_reg  <= 1'b1;
    end else begin
      rf_wren_reg <= 1'b0;
    end
  end

  assign rf_wren        = rf_wren_reg;
  assign rf_waddr       = rf_entry_reg.waddr;
  assign rf_wdata0      = rf_entry_reg.wdata0;
  assign rf_wdata1      = rf_entry_reg.wdata1;
  assign rf_alu_control = rf_entry_reg.op;

  // ---------------------------------------------------------------------------
  // Hazard compare against every live FIFO slot plus the live rf_* register.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] slot_hit0;
  logic [DEPTH-1:0] slot_hit1;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      wb_entry_t slot_entry;
      assign slot_entry    = wb_entry_t'(slot_bits[gi]);
      assign slot_hit0[gi] = slot_valid[gi] & dest_match(slot_entry, chk_addr0);
      assign slot_hit1[gi] = slot_valid[gi] & dest_match(slot_entry, chk_addr1);
    end
  endgenerate

  assign chk_busy0 = (|slot_hit0) | (rf_wren_reg & dest_match(rf_entry_reg, chk_addr0));
  assign chk_busy1 = (|slot_hit1) | (rf_wren_reg & dest_match(rf_entry_reg, chk_addr1));

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Scoreboard bench: every accepted result is pushed into an ordered queue of
//   expected register-file writes; a monitor pops and compares whenever the
//   DUT raises rf_wren. Occupancy, ready and hazard flags are derived from the
//   same queue of not-yet-written results.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [AW-1:0] in_waddr = '0;
  logic [DW-1:0] in_wdata0 = '0;
  logic [DW-1:0] in_wdata1 = '0;
  logic          wb_hold = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] chk_addr0 = '0;
  logic [AW-1:0] chk_addr1 = '0;
  logic          chk_busy0;
  logic          chk_busy1;
  logic [2:0]    fifo_count;
  logic          rf_wren;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata0;
  logic [DW-1:0] rf_wdata1;
  logic [3:0]    rf_alu_control;

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_waddr       (in_waddr),
    .in_wdata0      (in_wdata0),
    .in_wdata1      (in_wdata1),
    .wb_hold        (wb_hold),
    .flush          (flush),
    .chk_addr0      (chk_addr0),
    .chk_addr1      (chk_addr1),
    .chk_busy0      (chk_busy0),
    .chk_busy1      (chk_busy1),
    .fifo_count     (fifo_count),
    .rf_wren        (rf_wren),
    .rf_waddr       (rf_waddr),
    .rf_wdata0      (rf_wdata0),
    .rf_wdata1      (rf_wdata1),
    .rf_alu_control (rf_alu_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] waddr;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t exp_q[$];          // results accepted but not yet seen on rf_*
  exp_t live;              // result currently presented on rf_*
  bit   live_valid = 1'b0;
  bit   exp_wren_next = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit is_dual(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2);
  endfunction

  function automatic bit writes_reg(input exp_t e, input logic [AW-1:0] a);
    if (is_dual(e.op)) return (a == 5'd19) || (a == 5'd20);
    return a == e.waddr;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    bit b;
    b = live_valid && writes_reg(live, a);
    foreach (exp_q[i]) if (writes_reg(exp_q[i], a)) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: at each edge decide drain and acceptance from the number
  // of outstanding results, then record accepted results in order.
  // ---------------------------------------------------------------------------
  initial begin
    int  sz;
    bit  acc;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_wren_next = 1'b0;
      end else begin
        sz  = exp_q.size();
        acc = in_valid && !flush && (sz != DEPTH);
        exp_wren_next = !flush && !wb_hold && (sz > 0);
        if (flush) begin
          exp_q.delete();
        end else if (acc && in_op != 4'd0) begin
`ifdef WB_BYPASS_EN
          if (sz == 0 && !wb_hold) exp_wren_next = 1'b1;
`endif
          e.op = in_op; e.waddr = in_waddr; e.d0 = in_wdata0; e.d1 = in_wdata1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares each register-file write against the scoreboard head.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("rf_wren", rf_wren, exp_wren_next);
        live_valid = 1'b0;
        if (rf_wren) begin
          if (exp_q.size() == 0) begin
            check("rf_write_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rf_alu_control", rf_alu_control, e.op);
            check("rf_wdata0", rf_wdata0, e.d0);
            check("rf_wdata1", rf_wdata1, e.d1);
            if (!is_dual(e.op)) check("rf_waddr", rf_waddr, e.waddr);
            live = e;
            live_valid = 1'b1;
          end
        end
        check("fifo_count", fifo_count, exp_q.size());
      end
    end
  end

  // One stimulus cycle; checks ready and hazard flags once inputs have settled.
  task automatic drive(input bit v, input logic [3:0] op, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input bit hold, input bit fl);
    int sel;
    logic [AW-1:0] a[2];
    @(negedge clk);
    #2;
    in_valid = v; in_op = op; in_waddr = wa; in_wdata0 = d0; in_wdata1 = d1;
    wb_hold = hold; flush = fl;
    for (int k = 0; k < 2; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a[k] = 5'd19;
        1: a[k] = 5'd20;
        2: a[k] = AW'($urandom_range(0, 31));
        default: a[k] = (exp_q.size() > 0) ? exp_q[$urandom_range(0, exp_q.size()-1)].waddr
                                            : AW'($urandom_range(0, 31));
      endcase
    end
    chk_addr0 = a[0]; chk_addr1 = a[1];
    #1;
    check("in_ready", in_ready, !fl && (exp_q.size() != DEPTH));
    check("chk_busy0", chk_busy0, exp_busy(chk_addr0));
    check("chk_busy1", chk_busy1, exp_busy(chk_addr1));
    $display("cyc t=%0t v=%0b op=%0d wa=%0d hold=%0b flush=%0b rdy=%0b cnt=%0d wren=%0b",
             $time, v, op, wa, hold, fl, in_ready, fifo_count, rf_wren);
  endtask

  task automatic idle(input int n, input bit hold);
    for (int i = 0; i < n; i++) drive(0, 4'd0, '0, '0, '0, hold, 0);
  endtask

  function automatic logic [3:0] rand_op();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 4'd0;
    if (s == 1) return 4'd1;
    if (s == 2) return 4'd2;
    return 4'($urandom_range(3, 15));
  endfunction

  initial begin
    // Reset state
    #3;
    check("reset_in_ready", in_ready, 0);
    check("reset_rf_wren", rf_wren, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_chk_busy0", chk_busy0, 0);
    check("reset_rf_wdata0", rf_wdata0, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Dual op: HI/LO busy until committed
    drive(1, 4'd1, 5'd7, 32'd5, 32'd6, 0, 0);
    idle(4, 0);

    // Hold, fill with four singles, ready must drop, then ordered drain
    drive(1, 4'd3, 5'd30, 32'd5,  32'd0, 1, 0);
    drive(1, 4'd4, 5'd29, 32'd15, 32'd0, 1, 0);
    drive(1, 4'd5, 5'd28, 32'd25, 32'd0, 1, 0);
    drive(1, 4'd6, 5'd27, 32'd35, 32'd0, 1, 0);
    drive(1, 4'd7, 5'd26, 32'd45, 32'd0, 1, 0);   // refused: full
    idle(6, 0);

    // Full FIFO: pop and attempted push at the same edge
    for (int i = 0; i < 4; i++) drive(1, 4'd9, AW'(i + 1), DW'(100 + i), '0, 1, 0);
    drive(1, 4'd9, 5'd9, 32'd999, '0, 0, 0);       // refused, count -> 3
    idle(5, 0);

    // Flush with one write presented and one queued for R29
    drive(1, 4'd3, 5'd5,  32'h55, '0, 0, 0);
    drive(1, 4'd3, 5'd29, 32'h29, '0, 0, 0);
    drive(1, 4'd3, 5'd11, 32'h11, '0, 0, 1);       // dropped by flush
    idle(3, 0);

    // Op 0 accepted and dropped
    drive(1, 4'd0, 5'd3, 32'h3, '0, 0, 0);
    idle(2, 0);

    // Reset while draining with three entries left
    for (int i = 0; i < 4; i++) drive(1, 4'd8, AW'(i + 10), DW'(200 + i), '0, 1, 0);
    drive(0, 4'd0, '0, '0, '0, 0, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_rf_wren", rf_wren, 0);
    check("async_reset_fifo_count", fifo_count, 0);
    check("async_reset_in_ready", in_ready, 0);
    exp_q.delete();
    live_valid = 1'b0;
    exp_wren_next = 1'b0;
    in_valid = 1'b0; wb_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_fifo_count", fifo_count, 0);
    idle(2, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, rand_op(), AW'($urandom()), $urandom(), $urandom(),
            $urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0);
    end
    idle(10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
